scan_decoder: RTL and testbench

- Registered, parametrised N-to-2^N one-hot decoder for driving display digit enables, row selects and similar one-of-many lines.
- Two modes:
  - Direct: decodes a loaded select value.
  - Scan: internal prescaled counter auto-cycles through all outputs and pulses a wrap flag once per full sweep.
- Sits between control logic and multiplexed output drivers.

---
 rtl/scan_decoder.sv | 100 ++++++++++
 tb/tb_scan_decoder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with a direct-select mode and a prescaled
// auto-scan mode. The scan mode pulses wrap once per full sweep of the outputs.
module scan_decoder #(
   parameter int SEL_W      = 2,
   parameter int DIV        = 4,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                mode,
   input  logic                load,
   input  logic [SEL_W-1:0]    sel,
   output logic [2**SEL_W-1:0] y,
   output logic [SEL_W-1:0]    idx,
   output logic                wrap
);

   localparam int OUT_W = 2**SEL_W;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
   localparam logic [OUT_W-1:0] Y_IDLE  = {OUT_W{ACTIVE_LOW}};

   typedef enum logic [1:0] {
      ST_BLANK  = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   cnt_eff;
   logic               wrap_q, wrap_d;
   logic [OUT_W-1:0]   y_q, y_d;
   logic [OUT_W-1:0]   onehot;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_BLANK;
         idx_q   <= '0;
         cnt_q   <= '0;
         wrap_q  <= 1'b0;
         y_q     <= Y_IDLE;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         wrap_q  <= wrap_d;
         y_q     <= y_d;
      end
   end

   // A scan entered from any other state restarts the prescaler from zero,
   // so a count left frozen by BLANK never shortens the first dwell.
   assign cnt_eff = (state_q == ST_SCAN) ? cnt_q : '0;

   always_comb begin
      state_d = ST_BLANK;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      wrap_d  = 1'b0;
      if (en) state_d = mode ? ST_SCAN : ST_DIRECT;

      case (state_d)
         ST_DIRECT: begin
            cnt_d = '0;
            if (load) idx_d = sel;
         end
         ST_SCAN: begin
            if (load) begin
               idx_d = sel;
               cnt_d = '0;
            end else if (cnt_eff == CNT_MAX) begin
               cnt_d  = '0;
               idx_d  = idx_q + 1'b1;
               wrap_d = (idx_q == '1);
            end else begin
               cnt_d = cnt_eff + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Decode from the next-state index so y and idx update on the same edge.
   for (genvar gi = 0; gi < OUT_W; gi++) begin : g_dec
      assign onehot[gi] = (idx_d == SEL_W'(gi));
   end

   always_comb begin
      y_d = Y_IDLE;
      if (state_d != ST_BLANK) y_d = onehot ^ Y_IDLE;
   end

   assign y    = y_q;
   assign idx  = idx_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed-vector bench for scan_decoder: a default instance (SEL_W=2, DIV=4)
// and an 8-output active-low instance with DIV=1.
module tb_scan_decoder;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n_a, en_a, mode_a, load_a;
   logic [1:0] sel_a;
   logic [3:0] y_a;
   logic [1:0] idx_a;
   logic       wrap_a;

   logic       rst_n_b, en_b, mode_b, load_b;
   logic [2:0] sel_b;
   logic [7:0] y_b;
   logic [2:0] idx_b;
   logic       wrap_b;

   int n_cmp = 0;
   int n_err = 0;

   scan_decoder #(.SEL_W(2), .DIV(4), .ACTIVE_LOW(1'b0)) u_dut_a (
      .clk(clk), .rst_n(rst_n_a), .en(en_a), .mode(mode_a), .load(load_a),
      .sel(sel_a), .y(y_a), .idx(idx_a), .wrap(wrap_a)
   );

   scan_decoder #(.SEL_W(3), .DIV(1), .ACTIVE_LOW(1'b1)) u_dut_b (
      .clk(clk), .rst_n(rst_n_b), .en(en_b), .mode(mode_b), .load(load_b),
      .sel(sel_b), .y(y_b), .idx(idx_b), .wrap(wrap_b)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_idx;

      rst_n_a = 1'b0; en_a = 1'b0; mode_a = 1'b0; load_a = 1'b0; sel_a = '0;
      rst_n_b = 1'b0; en_b = 1'b0; mode_b = 1'b0; load_b = 1'b0; sel_b = '0;
      tick(); tick();
      rst_n_a = 1'b1; rst_n_b = 1'b1;
      tick();
      check_val("rst_y_a", 32'(y_a), 32'h0);
      check_val("rst_idx_a", 32'(idx_a), 32'h0);
      check_val("rst_wrap_a", 32'(wrap_a), 32'h0);
      check_val("rst_y_b", 32'(y_b), 32'hFF);

      // Direct decode: load 0..3 on successive cycles.
      en_a = 1'b1; mode_a = 1'b0; load_a = 1'b1;
      for (int s = 0; s < 4; s++) begin
         sel_a = 2'(s);
         tick();
         check_val($sformatf("dir_y_%0d", s), 32'(y_a), 32'(1) << s);
         check_val($sformatf("dir_idx_%0d", s), 32'(idx_a), 32'(s));
         check_val($sformatf("dir_wrap_%0d", s), 32'(wrap_a), 32'h0);
      end
      sel_a = 2'd0;
      tick();
      check_val("dir_reload0", 32'(y_a), 32'h1);
      load_a = 1'b0;

      // Scan sweep from idx 0: steps every 4 clocks, wrap at clock 16.
      mode_a = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         exp_idx = (k / 4) % 4;
         check_val($sformatf("scan_idx_%0d", k), 32'(idx_a), 32'(exp_idx));
         check_val($sformatf("scan_y_%0d", k), 32'(y_a), 32'(1) << exp_idx);
         check_val($sformatf("scan_wrap_%0d", k), 32'(wrap_a), (k == 16) ? 32'h1 : 32'h0);
      end

      // Reach idx=1, cnt=2, then load 3.
      for (int k = 0; k < 6; k++) tick();
      check_val("pre_load_idx", 32'(idx_a), 32'h1);
      load_a = 1'b1; sel_a = 2'd3;
      tick();
      load_a = 1'b0;
      check_val("load_idx", 32'(idx_a), 32'h3);
      check_val("load_y", 32'(y_a), 32'h8);
      tick(); tick(); tick();
      check_val("load_hold_idx", 32'(idx_a), 32'h3);
      check_val("load_hold_wrap", 32'(wrap_a), 32'h0);
      tick();
      check_val("load_wrap_idx", 32'(idx_a), 32'h0);
      check_val("load_wrap", 32'(wrap_a), 32'h1);

      // Load at terminal count: load value wins, no extra step.
      tick(); tick(); tick();
      load_a = 1'b1; sel_a = 2'd2;
      tick();
      load_a = 1'b0;
      check_val("tc_load_idx", 32'(idx_a), 32'h2);
      check_val("tc_load_wrap", 32'(wrap_a), 32'h0);
      // Terminal count at idx 3 with load sel=0: no wrap pulse.
      for (int k = 0; k < 4; k++) tick();
      check_val("tc_pre_idx", 32'(idx_a), 32'h3);
      tick(); tick(); tick();
      load_a = 1'b1; sel_a = 2'd0;
      tick();
      load_a = 1'b0;
      check_val("tc_sel0_idx", 32'(idx_a), 32'h0);
      check_val("tc_sel0_wrap", 32'(wrap_a), 32'h0);

      // Blank/freeze at idx 2 with a partial count.
      for (int k = 0; k < 9; k++) tick();
      check_val("blk_pre_idx", 32'(idx_a), 32'h2);
      en_a = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      check_val("blk_y", 32'(y_a), 32'h0);
      check_val("blk_idx", 32'(idx_a), 32'h2);
      check_val("blk_wrap", 32'(wrap_a), 32'h0);
      en_a = 1'b1;
      tick();
      check_val("unblk_y", 32'(y_a), 32'h4);
      tick(); tick();
      check_val("unblk_hold_idx", 32'(idx_a), 32'h2);
      tick();
      check_val("unblk_step_idx", 32'(idx_a), 32'h3);
      check_val("unblk_step_y", 32'(y_a), 32'h8);

      // Asynchronous reset on a wrap pulse, then with a nonzero idx.
      for (int k = 0; k < 4; k++) tick();
      check_val("pre_rst_wrap", 32'(wrap_a), 32'h1);
      rst_n_a = 1'b0;
      #2;
      check_val("arst_y", 32'(y_a), 32'h0);
      check_val("arst_wrap", 32'(wrap_a), 32'h0);
      rst_n_a = 1'b1;
      mode_a = 1'b0; load_a = 1'b1; sel_a = 2'd2;
      tick();
      load_a = 1'b0;
      check_val("pre_rst2_idx", 32'(idx_a), 32'h2);
      rst_n_a = 1'b0;
      #2;
      check_val("arst2_idx", 32'(idx_a), 32'h0);
      check_val("arst2_y", 32'(y_a), 32'h0);
      rst_n_a = 1'b1;

      // 8-output active-low instance, DIV=1: advances every clock.
      check_val("b_idle_y", 32'(y_b), 32'hFF);
      en_b = 1'b1; mode_b = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         exp_idx = k % 8;
         check_val($sformatf("b_idx_%0d", k), 32'(idx_b), 32'(exp_idx));
         check_val($sformatf("b_y_%0d", k), 32'(y_b), 32'hFF & ~(32'(1) << exp_idx));
         check_val($sformatf("b_wrap_%0d", k), 32'(wrap_b), (exp_idx == 0) ? 32'h1 : 32'h0);
      end
      tick(); tick(); tick();
      en_b = 1'b0;
      tick();
      check_val("b_blank_y", 32'(y_b), 32'hFF);
      check_val("b_blank_idx", 32'(idx_b), 32'h3);
      tick();
      check_val("b_blank_hold", 32'(idx_b), 32'h3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
